// File: rtl/mio_pkg.sv
// rtl/mio_pkg.sv - shared region codes, FSM encoding and error data for the MIO responder
package mio_pkg;

  localparam logic [3:0] RGN_RAM  = 4'h0;
  localparam logic [3:0] RGN_GPIO = 4'hE;
  localparam logic [3:0] RGN_CNT  = 4'hF;

  localparam logic [31:0] ERR_RDATA = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mio_state_e;

endpackage

// File: rtl/mio_responder_if.sv
// rtl/mio_responder_if.sv - CPU memory/IO handshake bundle
interface mio_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr_in;
  logic [31:0] Data_in;
  logic [31:0] Data_out;
  logic        MIO_ready;

  modport master (output MemRead, MemWrite, Addr_in, Data_in, input Data_out, MIO_ready);
  modport slave  (input MemRead, MemWrite, Addr_in, Data_in, output Data_out, MIO_ready);
endinterface

// File: rtl/mio_ram.sv
// rtl/mio_ram.sv - single-port synchronous word RAM with one-cycle read
module mio_ram #(
  parameter int RAM_AW = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**RAM_AW];
  logic [31:0] rdata_q;

  // Write when enabled; read port always registers the addressed word (read-old on collision)
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mio_responder.sv
// rtl/mio_responder.sv - decodes CPU accesses to RAM, GPIO and cycle counter with fixed 2-cycle ready
module mio_responder
  import mio_pkg::*;
#(
  parameter int RAM_AW = 10,
  parameter int LED_W  = 8,
  parameter int SW_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  mio_responder_if.slave   bus,
  output logic [LED_W-1:0] led_out,
  input  logic [SW_W-1:0]  sw_in,
  output logic [31:0]      cycle_cnt,
  output logic             bus_err
);

  mio_state_e        state_q, state_d;
  logic [3:0]        rgn_q, rgn_d;
  logic [RAM_AW-1:0] widx_q, widx_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rd_q, rd_d;
  logic [31:0]       data_out_q, data_out_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              bus_err_q, bus_err_d;

  logic              ram_we;
  logic [31:0]       ram_rdata;
  logic              ram_hit;
  logic [31:0]       resp_data;
  logic              unused_addr_bits;

  // Only the region nibble and the word index matter; the rest alias
  assign unused_addr_bits = ^{bus.Addr_in[27:RAM_AW+2], bus.Addr_in[1:0]};

  mio_ram #(.RAM_AW(RAM_AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (widx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // RAM read data only arrives in RESP, so it bypasses rd_q
  assign ram_hit       = !err_q && !wr_q && (rgn_q == RGN_RAM);
  assign resp_data     = ram_hit ? ram_rdata : rd_q;
  assign bus.Data_out  = (state_q == ST_RESP) ? resp_data : data_out_q;
  assign bus.MIO_ready = (state_q == ST_RESP);
  assign led_out       = led_q;
  assign cycle_cnt     = cnt_q;
  assign bus_err       = bus_err_q;

  // Next-state, request latching, commit and counter logic
  always_comb begin
    state_d    = state_q;
    rgn_d      = rgn_q;
    widx_d     = widx_q;
    wr_d       = wr_q;
    err_d      = err_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    data_out_d = data_out_q;
    led_d      = led_q;
    cnt_d      = cnt_q + 32'd1;
    bus_err_d  = bus_err_q;
    ram_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.MemRead ^ bus.MemWrite) begin
          rgn_d   = bus.Addr_in[31:28];
          widx_d  = bus.Addr_in[RAM_AW+1:2];
          wr_d    = bus.MemWrite;
          wdata_d = bus.Data_in;
          err_d   = 1'b0;
          state_d = ST_ACCESS;
        end else if (bus.MemRead && bus.MemWrite) begin
          // Conflicting request: pass through ACCESS so latency stays fixed
          wr_d      = 1'b0;
          err_d     = 1'b1;
          bus_err_d = 1'b1;
          state_d   = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        rd_d    = '0;
        if (err_q) begin
          rd_d = ERR_RDATA;
        end else if (wr_q) begin
          case (rgn_q)
            RGN_RAM:  ram_we = !reset;
            RGN_GPIO: if (!widx_q[0]) led_d = wdata_q[LED_W-1:0];
            RGN_CNT:  cnt_d = wdata_q;
            default:  ;
          endcase
        end else begin
          case (rgn_q)
            RGN_GPIO: rd_d = widx_q[0] ? 32'(sw_in) : 32'(led_q);
            RGN_CNT:  rd_d = cnt_q;
            default:  rd_d = '0;
          endcase
        end
      end
      ST_RESP: begin
        data_out_d = resp_data;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any in-flight access
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rgn_q      <= '0;
      widx_q     <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      wdata_q    <= '0;
      rd_q       <= '0;
      data_out_q <= '0;
      led_q      <= '0;
      cnt_q      <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rgn_q      <= rgn_d;
      widx_q     <= widx_d;
      wr_q       <= wr_d;
      err_q      <= err_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      data_out_q <= data_out_d;
      led_q      <= led_d;
      cnt_q      <= cnt_d;
      bus_err_q  <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_mio_responder.sv
// tb/tb_mio_responder.sv - directed self-checking bench for mio_responder
module tb_mio_responder;

  logic        clk;
  logic        reset;
  logic [7:0]  led_out;
  logic [7:0]  sw_in;
  logic [31:0] cycle_cnt;
  logic        bus_err;

  int n_pass;
  int n_total;
  int cyc;
  int dbl;
  logic prev_rdy;

  mio_responder_if bus();

  mio_responder #(.RAM_AW(10), .LED_W(8), .SW_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .led_out   (led_out),
    .sw_in     (sw_in),
    .cycle_cnt (cycle_cnt),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.MIO_ready === 1'b1 && prev_rdy === 1'b1) dbl <= dbl + 1;
    prev_rdy <= bus.MIO_ready;
  end

  // Present one request in the cycle after the next edge (cycle 0) and wait for ready
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, output int lat, output logic [31:0] dout,
                        output int at);
    @(posedge clk); #1;
    bus.MemRead  = rd;
    bus.MemWrite = wr;
    bus.Addr_in  = addr;
    bus.Data_in  = data;
    lat  = -1;
    dout = '0;
    at   = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (bus.MIO_ready === 1'b1) begin
        lat  = k;
        dout = bus.Data_out;
        at   = cyc;
        break;
      end
    end
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (bus.MIO_ready !== 1'b0) $display("FAIL rst_ready got %0b exp 0", bus.MIO_ready); else n_pass++;
    n_total++; if (bus.Data_out !== 32'h0) $display("FAIL rst_dout got %h exp 00000000", bus.Data_out); else n_pass++;
    n_total++; if (led_out !== 8'h0) $display("FAIL rst_led got %h exp 00", led_out); else n_pass++;
    n_total++; if (cycle_cnt !== 32'h0) $display("FAIL rst_cnt got %h exp 00000000", cycle_cnt); else n_pass++;
    n_total++; if (bus_err !== 1'b0) $display("FAIL rst_err got %0b exp 0", bus_err); else n_pass++;
    reset = 1'b0;
    // Write to LED, then reset while in ACCESS
    @(posedge clk); #1;
    bus.MemWrite = 1'b1;
    bus.Addr_in  = 32'hE000_0000;
    bus.Data_in  = 32'h0000_00A5;
    @(posedge clk); #1;
    reset = 1'b1;
    bus.MemWrite = 1'b0;
    @(posedge clk); #1;
    n_total++; if (bus.MIO_ready !== 1'b0) $display("FAIL midrst_ready got %0b exp 0", bus.MIO_ready); else n_pass++;
    n_total++; if (led_out !== 8'h0) $display("FAIL midrst_led got %h exp 00", led_out); else n_pass++;
    reset = 1'b0;
    @(posedge clk); #1;
    n_total++; if (bus.MIO_ready !== 1'b0) $display("FAIL midrst_ready2 got %0b exp 0", bus.MIO_ready); else n_pass++;
    n_total++; if (led_out !== 8'h0) $display("FAIL midrst_led2 got %h exp 00", led_out); else n_pass++;
  endtask

  task automatic test_ram();
    int lat, at;
    logic [31:0] d;
    do_req(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, lat, d, at);
    n_total++; if (lat !== 2) $display("FAIL ram_wr_lat got %0d exp 2", lat); else n_pass++;
    do_req(1'b1, 1'b0, 32'h0000_0010, 32'h0, lat, d, at);
    n_total++; if (lat !== 2) $display("FAIL ram_rd_lat got %0d exp 2", lat); else n_pass++;
    n_total++; if (d !== 32'h1234_5678) $display("FAIL ram_rd got %h exp 12345678", d); else n_pass++;
    do_req(1'b1, 1'b0, 32'h0000_1010, 32'h0, lat, d, at);
    n_total++; if (d !== 32'h1234_5678) $display("FAIL ram_alias got %h exp 12345678", d); else n_pass++;
    do_req(1'b1, 1'b0, 32'h0000_0014, 32'h0, lat, d, at);
    n_total++; if (d === 32'h1234_5678) $display("FAIL ram_neighbour got %h exp other than 12345678", d); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat1, at1, lat2, at2;
    logic [31:0] d;
    dbl = 0;
    do_req(1'b0, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, lat1, d, at1);
    do_req(1'b1, 1'b0, 32'h0000_0000, 32'h0, lat2, d, at2);
    n_total++; if (lat1 !== 2 || lat2 !== 2) $display("FAIL b2b_lat got %0d,%0d exp 2,2", lat1, lat2); else n_pass++;
    n_total++; if (at2 - at1 !== 3) $display("FAIL b2b_gap got %0d exp 3", at2 - at1); else n_pass++;
    n_total++; if (d !== 32'hCAFE_F00D) $display("FAIL b2b_data got %h exp cafef00d", d); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (dbl !== 0) $display("FAIL b2b_double_ready got %0d exp 0", dbl); else n_pass++;
  endtask

  task automatic test_gpio();
    int lat, at;
    logic [31:0] d;
    sw_in = 8'h3C;
    do_req(1'b0, 1'b1, 32'hE000_0000, 32'h0000_00A5, lat, d, at);
    n_total++; if (led_out !== 8'hA5) $display("FAIL gpio_led got %h exp a5", led_out); else n_pass++;
    do_req(1'b1, 1'b0, 32'hE000_0004, 32'h0, lat, d, at);
    n_total++; if (d !== 32'h0000_003C) $display("FAIL gpio_sw got %h exp 0000003c", d); else n_pass++;
    do_req(1'b1, 1'b0, 32'hE000_0000, 32'h0, lat, d, at);
    n_total++; if (d !== 32'h0000_00A5) $display("FAIL gpio_led_rd got %h exp 000000a5", d); else n_pass++;
    do_req(1'b0, 1'b1, 32'hE000_0004, 32'h0000_00FF, lat, d, at);
    n_total++; if (lat !== 2) $display("FAIL gpio_swwr_lat got %0d exp 2", lat); else n_pass++;
    n_total++; if (led_out !== 8'hA5) $display("FAIL gpio_swwr_led got %h exp a5", led_out); else n_pass++;
    do_req(1'b1, 1'b0, 32'hE000_0004, 32'h0, lat, d, at);
    n_total++; if (d !== 32'h0000_003C) $display("FAIL gpio_swwr_rd got %h exp 0000003c", d); else n_pass++;
  endtask

  task automatic test_counter();
    int lat, at;
    logic [31:0] d;
    do_req(1'b0, 1'b1, 32'hF000_0000, 32'hFFFF_FFFE, lat, d, at);
    n_total++; if (cycle_cnt !== 32'hFFFF_FFFE) $display("FAIL cnt_load got %h exp fffffffe", cycle_cnt); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (cycle_cnt !== 32'hFFFF_FFFF) $display("FAIL cnt_inc got %h exp ffffffff", cycle_cnt); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (cycle_cnt !== 32'h0) $display("FAIL cnt_wrap got %h exp 00000000", cycle_cnt); else n_pass++;
    // Counter is 1 in the request cycle and 2 in ACCESS, so the read returns 2
    do_req(1'b1, 1'b0, 32'hF000_0000, 32'h0, lat, d, at);
    n_total++; if (d !== 32'h0000_0002) $display("FAIL cnt_rd got %h exp 00000002", d); else n_pass++;
    n_total++; if (cycle_cnt !== 32'h0000_0003) $display("FAIL cnt_after_rd got %h exp 00000003", cycle_cnt); else n_pass++;
  endtask

  task automatic test_err_unmapped();
    int lat, at;
    logic [31:0] d;
    do_req(1'b0, 1'b1, 32'h5000_0000, 32'hFFFF_FFFF, lat, d, at);
    n_total++; if (lat !== 2) $display("FAIL unmap_wr_lat got %0d exp 2", lat); else n_pass++;
    do_req(1'b1, 1'b0, 32'h5000_0000, 32'h0, lat, d, at);
    n_total++; if (d !== 32'h0) $display("FAIL unmap_rd got %h exp 00000000", d); else n_pass++;
    n_total++; if (bus_err !== 1'b0) $display("FAIL unmap_err got %0b exp 0", bus_err); else n_pass++;
    do_req(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, lat, d, at);
    n_total++; if (lat !== 2) $display("FAIL err_lat got %0d exp 2", lat); else n_pass++;
    n_total++; if (d !== 32'h0) $display("FAIL err_dout got %h exp 00000000", d); else n_pass++;
    n_total++; if (bus_err !== 1'b1) $display("FAIL err_flag got %0b exp 1", bus_err); else n_pass++;
    do_req(1'b1, 1'b0, 32'h0000_0010, 32'h0, lat, d, at);
    n_total++; if (d !== 32'h1234_5678) $display("FAIL err_ram_kept got %h exp 12345678", d); else n_pass++;
    n_total++; if (bus_err !== 1'b1) $display("FAIL err_sticky got %0b exp 1", bus_err); else n_pass++;
    n_total++; if (led_out !== 8'hA5) $display("FAIL err_led_kept got %h exp a5", led_out); else n_pass++;
  endtask

  initial begin
    clk          = 1'b0;
    reset        = 1'b1;
    sw_in        = 8'h00;
    cyc          = 0;
    dbl          = 0;
    prev_rdy     = 1'b0;
    n_pass       = 0;
    n_total      = 0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.Addr_in  = 32'h0;
    bus.Data_in  = 32'h0;
    test_reset();
    test_ram();
    test_back_to_back();
    test_gpio();
    test_counter();
    test_err_unmapped();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
